riscv_instr_port_arbiter: RTL

- Shares the single instruction-memory request/grant/rvalid port between two fetch requesters.
  - Port 0: the prefetch buffer of the IF stage.
  - Port 1: an auxiliary fetcher, such as a debug-unit memory reader or an L0 refill engine.
- Tracks outstanding transactions in an in-order owner FIFO, so each rvalid/rdata returns to the master that issued the request.
- Sits between the IF stage and the instruction cache/memory, and is transparent when only port 0 is active.

---
 rtl/riscv_instr_port_arbiter.sv | 119 +++++++++++
 1 files changed

// File: rtl/riscv_instr_port_arbiter.sv
// Two-master arbiter for the instruction-memory req/gnt/rvalid port.
// An in-order owner FIFO steers each response back to the master that issued it.
module riscv_instr_port_arbiter #(
   parameter int RDATA_WIDTH     = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   m0_req_i,
   input  logic [31:0]            m0_addr_i,
   output logic                   m0_gnt_o,
   output logic                   m0_rvalid_o,
   output logic [RDATA_WIDTH-1:0] m0_rdata_o,
   input  logic                   m1_req_i,
   input  logic [31:0]            m1_addr_i,
   output logic                   m1_gnt_o,
   output logic                   m1_rvalid_o,
   output logic [RDATA_WIDTH-1:0] m1_rdata_o,
   output logic                   instr_req_o,
   output logic [31:0]            instr_addr_o,
   input  logic                   instr_gnt_i,
   input  logic                   instr_rvalid_i,
   input  logic [RDATA_WIDTH-1:0] instr_rdata_i,
   output logic                   busy_o
);

   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

   logic             owner_q [MAX_OUTSTANDING];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             lock_q;
   logic             lock_id_q;
   logic             rr_last_q;

   logic sel;
   logic sel_req;
   logic full;
   logic grant;
   logic pop;
   logic head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // A locked port keeps ownership until memory accepts it, so the address never moves mid-handshake.
   always_comb begin
      sel = 1'b0;
      if (lock_q)
         sel = lock_id_q;
      else if (m0_req_i && !m1_req_i)
         sel = 1'b0;
      else if (m1_req_i && !m0_req_i)
         sel = 1'b1;
      else if (m0_req_i && m1_req_i)
         sel = ~rr_last_q;
   end

   assign sel_req      = sel ? m1_req_i : m0_req_i;
   assign full         = (cnt_q == FULL_CNT);
   assign instr_req_o  = sel_req & ~full;
   assign instr_addr_o = sel ? m1_addr_i : m0_addr_i;
   assign grant        = instr_req_o & instr_gnt_i;
   assign m0_gnt_o     = grant & ~sel;
   assign m1_gnt_o     = grant & sel;

   // Responses with no recorded owner (e.g. left over from before a reset) are dropped.
   assign pop         = instr_rvalid_i & (cnt_q != '0);
   assign head        = owner_q[rd_ptr_q];
   assign m0_rvalid_o = pop & ~head;
   assign m1_rvalid_o = pop & head;
   assign m0_rdata_o  = instr_rdata_i;
   assign m1_rdata_o  = instr_rdata_i;

   assign busy_o = instr_req_o | lock_q | (cnt_q != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         rr_last_q <= 1'b1;
      end else begin
         if (instr_req_o && !instr_gnt_i) begin
            lock_q    <= 1'b1;
            lock_id_q <= sel;
         end else if (grant) begin
            lock_q <= 1'b0;
         end

         if (grant) begin
            rr_last_q <= sel;
            wr_ptr_q  <= ptr_inc(wr_ptr_q);
         end
         if (pop)
            rd_ptr_q <= ptr_inc(rd_ptr_q);

         case ({grant, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Owner entries are only read behind a nonzero count, so they need no reset.
   always_ff @(posedge clk) begin
      if (grant)
         owner_q[wr_ptr_q] <= sel;
   end

endmodule
